// File: rtl/shift_left_seq.sv
// Multi-pass lane shifter: left-shifts a word by 0..15 lanes, at most MAX_STEP lanes per cycle,
// inserting a fill lane below. Optional pass counter behind SHL_SEQ_PERF_CNT_EN.

module shl_lane #(
  parameter int LANE_W   = 12,
  parameter int MAX_STEP = 5
) (
  input  logic [MAX_STEP:0][LANE_W-1:0] win,
  input  logic [3:0]                    step,
  output logic [LANE_W-1:0]             q
);
  always_comb begin
    q = win[0];
    for (int k = 1; k <= MAX_STEP; k++)
      if (step == 4'(k)) q = win[k];
  end
endmodule

module shift_left_seq #(
  parameter int LANE_W   = 12,
  parameter int LANES    = 8,
  parameter int MAX_STEP = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*LANE_W-1:0] in_data,
  input  logic [3:0]              in_amt,
  input  logic [LANE_W-1:0]       in_fill,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*LANE_W-1:0] out_data,
  output logic                    busy
`ifdef SHL_SEQ_PERF_CNT_EN
  ,output logic [15:0]            pass_cnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] MAX_STEP_W = 4'(MAX_STEP);

  state_t                       state;
  logic [LANES-1:0][LANE_W-1:0] data_q, data_nxt;
  logic [LANE_W-1:0]            fill_q;
  logic [3:0]                   rem_q, step, rem_nxt;

  assign step     = (rem_q > MAX_STEP_W) ? MAX_STEP_W : rem_q;
  assign rem_nxt  = rem_q - step;
  assign out_data = data_q;

  // Lane i of a pass picks data lane i-step, or fill when that falls below lane 0.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [MAX_STEP:0][LANE_W-1:0] win;
    for (genvar k = 0; k <= MAX_STEP; k++) begin : g_win
      if (i >= k) begin : g_src
        assign win[k] = data_q[i-k];
      end else begin : g_fill
        assign win[k] = fill_q;
      end
    end
    shl_lane #(.LANE_W(LANE_W), .MAX_STEP(MAX_STEP)) u_lane (
      .win (win),
      .step(step),
      .q   (data_nxt[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      data_q    <= '0;
      fill_q    <= '0;
      rem_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            data_q   <= in_data;
            fill_q   <= in_fill;
            rem_q    <= in_amt;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          data_q <= data_nxt;
          rem_q  <= rem_nxt;
          if (rem_nxt == 4'd0) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHL_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 pass_cnt <= '0;
    else if (state == RUN && pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_shift_left_seq.sv
// Scoreboard bench for shift_left_seq: stimulus pushes expected words, a monitor checks results.
`timescale 1ns/1ps
module tb_shift_left_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [95:0] in_data = '0;
  logic [3:0]  in_amt = '0;
  logic [11:0] in_fill = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [95:0] out_data;
  logic        busy;
`ifdef SHL_SEQ_PERF_CNT_EN
  logic [15:0] pass_cnt;
`endif

  shift_left_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_amt(in_amt), .in_fill(in_fill),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef SHL_SEQ_PERF_CNT_EN
    , .pass_cnt(pass_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [95:0] d;
    int          p;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  localparam logic [95:0] D   = 96'h008_007_006_005_004_003_002_001;
  localparam logic [95:0] E3  = 96'h005_004_003_002_001_ABC_ABC_ABC;
  localparam logic [95:0] E7  = 96'h001_0F0_0F0_0F0_0F0_0F0_0F0_0F0;
  localparam logic [95:0] E15 = 96'h5A5_5A5_5A5_5A5_5A5_5A5_5A5_5A5;
  localparam logic [95:0] E8  = 96'h777_777_777_777_777_777_777_777;
  localparam logic [95:0] E6  = 96'h002_001_222_222_222_222_222_222;
  localparam logic [95:0] E5  = 96'h003_002_001_111_111_111_111_111;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired", nm);
  endtask

  // Monitor: first cycle of out_valid pops and checks; later cycles check hold stability.
  logic        was_valid = 1'b0;
  logic [95:0] hold;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!was_valid) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_out");
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("out_data", out_data, e.d);
          chk("latency", 96'(cyc - e.acc), 96'(e.p));
        end
        hold = out_data;
      end else begin
        chk("hold_stable", out_data, hold);
      end
    end
    was_valid = rst_n && out_valid;
  end

  task automatic send(input logic [95:0] d, input logic [3:0] amt, input logic [11:0] f,
                      input logic [95:0] exp, input int p, input bit track);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("accept_wait");
      return;
    end
    in_valid = 1'b1; in_data = d; in_amt = amt; in_fill = f;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (track) sb.push_back('{d: exp, p: p, acc: cyc});
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(in_ready && !busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(in_ready && !busy)) fail_now("idle_wait");
  endtask

  initial begin
    #3;
    chk("rst_in_ready", 96'(in_ready), 96'd0);
    chk("rst_out_valid", 96'(out_valid), 96'd0);
    chk("rst_busy", 96'(busy), 96'd0);
    chk("rst_out_data", out_data, 96'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", 96'(in_ready), 96'd1);

    send(D, 4'd3,  12'hABC, E3,  1, 1'b1); wait_idle();
    send(D, 4'd7,  12'h0F0, E7,  2, 1'b1); wait_idle();
    send(D, 4'd0,  12'h999, D,   1, 1'b1); wait_idle();
    send(D, 4'd15, 12'h5A5, E15, 3, 1'b1); wait_idle();
    send(D, 4'd8,  12'h777, E8,  2, 1'b1); wait_idle();
    send(D, 4'd6,  12'h222, E6,  2, 1'b1); wait_idle();

    // Consumer stalls in DONE while extra requests are offered and must be dropped.
    out_ready = 1'b0;
    send(D, 4'd3, 12'hABC, E3, 1, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!out_valid) fail_now("done_wait");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = ~D; in_amt = 4'd1; in_fill = 12'h123;
      chk("stall_valid", 96'(out_valid), 96'd1);
      chk("stall_busy", 96'(busy), 96'd1);
      chk("stall_ready", 96'(in_ready), 96'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid", 96'(out_valid), 96'd0);
    @(posedge clk);
    #1;
    chk("release_ready", 96'(in_ready), 96'd1);
    repeat (4) @(negedge clk);

    // Abort an amt=10 request during its second pass.
    send(D, 4'd10, 12'h333, E8, 2, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 96'(busy), 96'd0);
    chk("abort_valid", 96'(out_valid), 96'd0);
    chk("abort_data", out_data, 96'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_hold_valid", 96'(out_valid), 96'd0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready", 96'(in_ready), 96'd1);
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_out", 96'(out_valid), 96'd0);
    end
    send(D, 4'd5, 12'h111, E5, 1, 1'b1); wait_idle();

`ifdef SHL_SEQ_PERF_CNT_EN
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("perf_rst", 96'(pass_cnt), 96'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(D, 4'd3,  12'hABC, E3,  1, 1'b1); wait_idle();
    send(D, 4'd7,  12'h0F0, E7,  2, 1'b1); wait_idle();
    send(D, 4'd15, 12'h5A5, E15, 3, 1'b1); wait_idle();
    chk("pass_cnt", 96'(pass_cnt), 96'd6);
`endif

    repeat (3) @(negedge clk);
    if (sb.size() != 0) fail_now("missing_out");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
